// File: rtl/gsx_led_deserializer_pkg.sv
// Shared constants for the GSX LED deserializer: frame geometry, LED byte
// positions within a frame, FSM state codes and a saturating-increment helper.
package gsx_led_deserializer_pkg;

   localparam int FRAME_BITS = 48;

   // Byte positions inside a frame (first bit shifted in lands in bit 47)
   localparam int POST_MSB = 47;
   localparam int POST_LSB = 40;
   localparam int C11_MSB  = 39;
   localparam int C11_LSB  = 32;
   localparam int C12_MSB  = 31;
   localparam int C12_LSB  = 24;
   localparam int C21_MSB  = 23;
   localparam int C21_LSB  = 16;
   localparam int C22_MSB  = 15;
   localparam int C22_LSB  = 8;
   localparam int FAN_MSB  = 7;
   localparam int FAN_LSB  = 0;

   localparam logic [1:0] ST_RESYNC = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_LOST   = 2'd2;

   function automatic logic [7:0] satInc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/gsx_led_deserializer_if.sv
// Serial GPIO expander link (BMC side drives SCLK/SLOAD/SDATA) plus the
// decoded LED/status outputs presented by the deserializer.
interface gsx_led_deserializer_if;

   logic       iSClock;
   logic       iSLoad;
   logic       iSData;
   logic [7:0] oPostCodeLed;
   logic [7:0] oDimmFltLed_CPU1_1;
   logic [7:0] oDimmFltLed_CPU1_2;
   logic [7:0] oDimmFltLed_CPU2_1;
   logic [7:0] oDimmFltLed_CPU2_2;
   logic [7:0] oFanFltLed;
   logic       oGsxValid;
   logic       oLinkLost;
   logic [7:0] oFrameErrCnt;

   modport master (
      output iSClock, iSLoad, iSData,
      input  oPostCodeLed, oDimmFltLed_CPU1_1, oDimmFltLed_CPU1_2,
             oDimmFltLed_CPU2_1, oDimmFltLed_CPU2_2, oFanFltLed,
             oGsxValid, oLinkLost, oFrameErrCnt
   );

   modport slave (
      input  iSClock, iSLoad, iSData,
      output oPostCodeLed, oDimmFltLed_CPU1_1, oDimmFltLed_CPU1_2,
             oDimmFltLed_CPU2_1, oDimmFltLed_CPU2_2, oFanFltLed,
             oGsxValid, oLinkLost, oFrameErrCnt
   );

endinterface

// File: rtl/gsx_led_deserializer_in_sync.sv
// Two-flop synchroniser for the three asynchronous GSX pins, plus a one-cycle
// pulse on each synchronised SCLK rising edge. SLOAD/SDATA share the same
// pipeline depth so they stay aligned with the edge pulse.
module gsx_in_sync (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iSClock,
   input  logic iSLoad,
   input  logic iSData,
   output logic oSLoad,
   output logic oSData,
   output logic oSClkRise
);

   logic [2:0] meta;
   logic [2:0] sync;
   logic       sClkPrev;

   // Synchronise {SData, SLoad, SClock} and remember the previous SCLK level
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         meta     <= '0;
         sync     <= '0;
         sClkPrev <= 1'b0;
      end else begin
         meta     <= {iSData, iSLoad, iSClock};
         sync     <= meta;
         sClkPrev <= sync[0];
      end
   end

   assign oSClkRise = sync[0] & ~sClkPrev;
   assign oSLoad    = sync[1];
   assign oSData    = sync[2];

endmodule

// File: rtl/gsx_led_deserializer.sv
// Deserializes 48-bit BMC GSX frames into LED bytes, with an N-identical-frame
// glitch filter, malformed-frame counting and an SCLK link-loss timeout.
module gsx_led_deserializer
   import gsx_led_deserializer_pkg::*;
#(
   parameter int MATCH_FRAMES  = 2,
   parameter int TIMEOUT_CYC   = 200000,
   parameter int CLEAR_ON_LOST = 1
) (
   input  logic                   iClk,
   input  logic                   iRst_n,
   gsx_led_deserializer_if.slave  gsx
);

   localparam int MW = $clog2(MATCH_FRAMES + 1);

   logic                  sLoad, sData, sEdge;
   logic [1:0]            state;
   logic [5:0]            bitCnt;
   logic [FRAME_BITS-2:0] shiftReg;
   logic [FRAME_BITS-1:0] cand, frameNext;
   logic [MW-1:0]         matchCnt, matchNext;
   logic [17:0]           tmoCnt;
   logic [7:0]            errCnt;
   logic [7:0]            postLed, c11Led, c12Led, c21Led, c22Led, fanLed;
   logic                  gsxValid, linkLost;
   logic                  lastBit, frameOk, frameErr, tmoHit;

   gsx_in_sync uSync (
      .iClk      (iClk),
      .iRst_n    (iRst_n),
      .iSClock   (gsx.iSClock),
      .iSLoad    (gsx.iSLoad),
      .iSData    (gsx.iSData),
      .oSLoad    (sLoad),
      .oSData    (sData),
      .oSClkRise (sEdge)
   );

   assign frameNext = {shiftReg, sData};
   assign lastBit   = (bitCnt == 6'(FRAME_BITS - 1));
   assign frameOk   = sEdge && (state == ST_SHIFT) && sLoad && lastBit;
   assign frameErr  = sEdge && (state == ST_SHIFT) && (sLoad ? !lastBit : lastBit);
   // An SCLK edge in the expiry cycle wins, so expiry is gated by !sEdge
   assign tmoHit    = !sEdge && (state != ST_LOST) && (tmoCnt == 18'(TIMEOUT_CYC - 1));

   // Match-filter count for the frame completing this cycle
   always_comb begin
      matchNext = MW'(1);
      if (frameNext == cand)
         matchNext = (matchCnt == MW'(MATCH_FRAMES)) ? matchCnt : matchCnt + MW'(1);
   end

   // Frame FSM: bit counting, shifting and SLOAD alignment
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= ST_RESYNC;
         bitCnt   <= '0;
         shiftReg <= '0;
      end else if (tmoHit) begin
         state <= ST_LOST;
      end else if (sEdge) begin
         case (state)
            ST_SHIFT: begin
               shiftReg <= frameNext[FRAME_BITS-2:0];
               if (sLoad) begin
                  bitCnt <= '0;
               end else if (lastBit) begin
                  bitCnt <= '0;
                  state  <= ST_RESYNC;
               end else begin
                  bitCnt <= bitCnt + 6'd1;
               end
            end
            ST_RESYNC, ST_LOST: begin
               if (sLoad) begin
                  state  <= ST_SHIFT;
                  bitCnt <= '0;
               end
            end
            default: state <= ST_RESYNC;
         endcase
      end
   end

   // Glitch filter, LED output registers and link status
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cand     <= '0;
         matchCnt <= '0;
         postLed  <= '0;
         c11Led   <= '0;
         c12Led   <= '0;
         c21Led   <= '0;
         c22Led   <= '0;
         fanLed   <= '0;
         gsxValid <= 1'b0;
         linkLost <= 1'b0;
      end else if (tmoHit) begin
         matchCnt <= '0;
         gsxValid <= 1'b0;
         linkLost <= 1'b1;
         if (CLEAR_ON_LOST != 0) begin
            c11Led <= '0;
            c12Led <= '0;
            c21Led <= '0;
            c22Led <= '0;
            fanLed <= '0;
         end
      end else if (sEdge) begin
         linkLost <= 1'b0;
         if (frameErr) begin
            matchCnt <= '0;
         end else if (frameOk) begin
            cand     <= frameNext;
            matchCnt <= matchNext;
            if (matchNext == MW'(MATCH_FRAMES)) begin
               postLed  <= frameNext[POST_MSB:POST_LSB];
               c11Led   <= frameNext[C11_MSB:C11_LSB];
               c12Led   <= frameNext[C12_MSB:C12_LSB];
               c21Led   <= frameNext[C21_MSB:C21_LSB];
               c22Led   <= frameNext[C22_MSB:C22_LSB];
               fanLed   <= frameNext[FAN_MSB:FAN_LSB];
               gsxValid <= 1'b1;
            end
         end
      end
   end

   // SCLK inactivity timer; holds at expiry while the link is lost
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)
         tmoCnt <= '0;
      else if (sEdge)
         tmoCnt <= '0;
      else if ((state != ST_LOST) && !tmoHit)
         tmoCnt <= tmoCnt + 18'd1;
   end

   // Saturating malformed-frame counter, cleared only by reset
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)
         errCnt <= '0;
      else if (frameErr)
         errCnt <= satInc8(errCnt);
   end

   assign gsx.oPostCodeLed       = postLed;
   assign gsx.oDimmFltLed_CPU1_1 = c11Led;
   assign gsx.oDimmFltLed_CPU1_2 = c12Led;
   assign gsx.oDimmFltLed_CPU2_1 = c21Led;
   assign gsx.oDimmFltLed_CPU2_2 = c22Led;
   assign gsx.oFanFltLed         = fanLed;
   assign gsx.oGsxValid          = gsxValid;
   assign gsx.oLinkLost          = linkLost;
   assign gsx.oFrameErrCnt       = errCnt;

endmodule

// File: tb/tb_gsx_led_deserializer.sv
// Directed bench for gsx_led_deserializer. Stimulus pushes the expected output
// snapshot whenever it expects the outputs to change; a monitor pops and
// compares on every observed output change.
module tb_gsx_led_deserializer;

   localparam int TMO = 1000;

   typedef struct packed {
      logic [7:0] post, c11, c12, c21, c22, fan;
      logic       valid, lost;
      logic [7:0] err;
   } obs_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   gsx_led_deserializer_if bus();

   gsx_led_deserializer #(
      .MATCH_FRAMES  (2),
      .TIMEOUT_CYC   (TMO),
      .CLEAR_ON_LOST (1)
   ) dut (
      .iClk   (clk),
      .iRst_n (rstN),
      .gsx    (bus)
   );

   obs_t obs;
   assign obs = {bus.oPostCodeLed, bus.oDimmFltLed_CPU1_1, bus.oDimmFltLed_CPU1_2,
                 bus.oDimmFltLed_CPU2_1, bus.oDimmFltLed_CPU2_2, bus.oFanFltLed,
                 bus.oGsxValid, bus.oLinkLost, bus.oFrameErrCnt};

   obs_t expQ[$];
   obs_t m;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   riseCyc = 0;
   int   lastChangeCyc = 0;

   localparam logic [47:0] F1 = 48'hA501_0204_08F0;
   localparam logic [47:0] FX = 48'h1122_3344_5566;
   localparam logic [47:0] FY = 48'h1234_5678_9ABC;
   localparam logic [47:0] FZ = 48'h8000_FF01_7EC3;
   localparam logic [47:0] FW = 48'h5AC3_3C0F_F099;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t withFrame(input obs_t c, input logic [47:0] f);
      obs_t r = c;
      r.post  = f[47:40];
      r.c11   = f[39:32];
      r.c12   = f[31:24];
      r.c21   = f[23:16];
      r.c22   = f[15:8];
      r.fan   = f[7:0];
      r.valid = 1'b1;
      return r;
   endfunction

   task automatic pushExp();
      expQ.push_back(m);
   endtask

   task automatic checkObs(input string name, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic checkInt(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   // One serial bit: data/load set up, SCLK rises just after an iClk edge
   task automatic sendBit(input logic d, input logic ld);
      @(posedge clk); #1;
      bus.iSData = d;
      bus.iSLoad = ld;
      repeat (3) @(posedge clk);
      #1 bus.iSClock = 1'b1;
      riseCyc = cyc;
      repeat (4) @(posedge clk);
      #1 bus.iSClock = 1'b0;
   endtask

   task automatic sendBits(input logic [47:0] f, input int n, input logic ldLast);
      for (int i = 0; i < n; i++)
         sendBit(f[47-i], ldLast && (i == n - 1));
   endtask

   task automatic sendFrame(input logic [47:0] f);
      sendBits(f, 48, 1'b1);
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s got=%0d_pending want=0_pending", name, expQ.size());
         expQ.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.iSClock = 1'b0;
      bus.iSLoad  = 1'b0;
      bus.iSData  = 1'b0;
      m = '0;

      fork
         begin : monitor
            obs_t prev;
            obs_t w;
            prev = '0;
            forever begin
               @(negedge clk);
               if (obs !== prev) begin
                  prev = obs;
                  lastChangeCyc = cyc;
                  if (expQ.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_change got=%h want=no_change", obs);
                  end else begin
                     w = expQ.pop_front();
                     checkObs("out_update", obs, w);
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checkObs("reset_state", obs, '0);

      // 1: sync bit, two identical frames, 3-cycle latency
      sendBit(1'b0, 1'b1);
      sendFrame(F1);
      m = withFrame(m, F1); pushExp();
      sendFrame(F1);
      waitDrain("t1_accept", 50);
      checkInt("t1_latency", lastChangeCyc - riseCyc, 3);

      // 2: X, Y, Y -> only Y ever appears
      sendFrame(FX);
      sendFrame(FY);
      m = withFrame(m, FY); pushExp();
      sendFrame(FY);
      waitDrain("t2_accept", 50);

      // 3: SLoad at bit 20 -> frame error, then good frames; error clears match
      m.err = 8'd1; pushExp();
      sendBits(FY, 21, 1'b1);
      waitDrain("t3_err", 50);
      sendFrame(FZ);
      m = withFrame(m, FZ); pushExp();
      sendFrame(FZ);
      waitDrain("t3_accept", 50);
      sendFrame(FX);
      m.err = 8'd2; pushExp();
      sendBits(FX, 5, 1'b1);
      sendFrame(FX);
      m = withFrame(m, FX); pushExp();
      sendFrame(FX);
      waitDrain("t3_match_clear", 50);

      // 4: 48 bits without SLoad -> overrun, bits ignored until SLoad
      m.err = 8'd3; pushExp();
      sendBits(FW, 48, 1'b0);
      waitDrain("t4_overrun", 50);
      sendBits(FY, 10, 1'b0);
      sendBit(1'b0, 1'b1);
      sendFrame(FW);
      m = withFrame(m, FW); pushExp();
      sendFrame(FW);
      waitDrain("t4_accept", 50);

      // 5: SCLK stops -> link lost, faults cleared, postcode held; recovery
      m.c11 = '0; m.c12 = '0; m.c21 = '0; m.c22 = '0; m.fan = '0;
      m.valid = 1'b0; m.lost = 1'b1; pushExp();
      waitDrain("t5_lost", TMO + 100);
      checkInt("t5_timeout_cycle", lastChangeCyc - riseCyc, 3 + TMO);
      m.lost = 1'b0; pushExp();
      sendBit(1'b0, 1'b1);
      waitDrain("t5_lost_clear", 50);
      sendFrame(FW);
      m = withFrame(m, FW); pushExp();
      sendFrame(FW);
      waitDrain("t5_recover", 50);

      // 6: 300 error frames saturate the counter, then reset mid-frame
      for (int k = 0; k < 300; k++) begin
         if (m.err != 8'hFF) begin
            m.err = m.err + 8'd1;
            pushExp();
         end
         sendBit(1'b0, 1'b1);
      end
      waitDrain("t6_saturate", 50);
      checkInt("t6_errcnt", int'(bus.oFrameErrCnt), 255);
      sendBits(FW, 10, 1'b0);
      m = '0; pushExp();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      waitDrain("t6_reset", 20);
      checkObs("t6_reset_outputs", obs, '0);
      sendBit(1'b0, 1'b1);
      sendFrame(FX);
      m = withFrame(m, FX); pushExp();
      sendFrame(FX);
      waitDrain("t6_after_reset", 50);

      checkInt("queue_empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
